// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass CALC and finish in one cycle.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  ALUCtrl,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [4:0] ALU_DIV  = 5'd11;
    localparam logic [4:0] ALU_DIVU = 5'd12;
    localparam logic [4:0] ALU_REM  = 5'd13;
    localparam logic [4:0] ALU_REMU = 5'd14;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q;
    logic [31:0] divisor_q;
    logic [31:0] rem_q;
    logic [31:0] result_q;
    logic        opRem_q;
    logic        negQ_q;
    logic        negR_q;
    logic        divZero_q;

    logic        isDivOp;
    logic        opSigned;
    logic        opRem;
    logic        aNeg;
    logic        bNeg;
    logic [31:0] absA;
    logic [31:0] absB;
    logic        divZero;

    always_comb begin
        isDivOp  = (ALUCtrl == ALU_DIV) || (ALUCtrl == ALU_DIVU) ||
                   (ALUCtrl == ALU_REM) || (ALUCtrl == ALU_REMU);
        opSigned = (ALUCtrl == ALU_DIV) || (ALUCtrl == ALU_REM);
        opRem    = (ALUCtrl == ALU_REM) || (ALUCtrl == ALU_REMU);
        aNeg     = opSigned & A[31];
        bNeg     = opSigned & B[31];
        absA     = aNeg ? (~A + 32'd1) : A;
        absB     = bNeg ? (~B + 32'd1) : B;
        divZero  = (B == 32'd0);
    end

`ifdef DIV_EARLY_OUT_EN
    logic        overflow;
    logic [31:0] specialResult;
    assign overflow      = opSigned && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign specialResult = divZero ? (opRem ? A : 32'hFFFF_FFFF)
                                   : (opRem ? 32'h0000_0000 : 32'h8000_0000);
`endif

    // rem_q < divisor always holds, so the 33-bit difference never loses a remainder bit.
    logic [32:0] shifted_d;
    logic [32:0] diff_d;
    logic        fits_d;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] final_d;

    always_comb begin
        shifted_d = {rem_q, quo_q[31]};
        diff_d    = shifted_d - {1'b0, divisor_q};
        fits_d    = ~diff_d[32];
        rem_d     = fits_d ? diff_d[31:0] : shifted_d[31:0];
        quo_d     = {quo_q[30:0], fits_d};
        if (opRem_q)
            final_d = negR_q ? (~rem_d + 32'd1) : rem_d;
        else if (divZero_q)
            final_d = 32'hFFFF_FFFF;
        else
            final_d = negQ_q ? (~quo_d + 32'd1) : quo_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            quo_q     <= 32'd0;
            divisor_q <= 32'd0;
            rem_q     <= 32'd0;
            result_q  <= 32'd0;
            opRem_q   <= 1'b0;
            negQ_q    <= 1'b0;
            negR_q    <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && isDivOp) begin
                        quo_q     <= absA;
                        divisor_q <= absB;
                        rem_q     <= 32'd0;
                        cnt_q     <= 5'd0;
                        opRem_q   <= opRem;
                        negQ_q    <= aNeg ^ bNeg;
                        negR_q    <= aNeg;
                        divZero_q <= divZero;
`ifdef DIV_EARLY_OUT_EN
                        if (divZero || overflow) begin
                            result_q <= specialResult;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
`else
                        state_q   <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_q <= final_d;
                        state_q  <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 Port rst, input, 1: asynchronous active-high reset.
REQ-003 Port A, input, 32: dividend; sampled only on an accepted start.
REQ-004 Port B, input, 32: divisor; sampled only on an accepted start.
REQ-005 Port ALUCtrl, input, 5: operation select using the defines.vh encodings `ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU.
REQ-006 Port start, input, 1: request pulse from the execute stage.
REQ-007 Port busy, output, 1: high whenever the state is not IDLE; the pipeline stalls on it.
REQ-008 Port done, output, 1: one-cycle pulse marking result valid.
REQ-009 Port result, output, 32: registered quotient or remainder.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-011 A start SHALL be accepted only in IDLE with start=1 and ALUCtrl equal to one of the four divide codes; any other start is ignored and the FSM stays in IDLE.
REQ-012 On acceptance the block SHALL latch the op, the operand signs, |A| and |B| (signed ops) or A and B (unsigned ops), clear the 32-bit remainder register, and enter CALC.
REQ-013 CALC SHALL run a restoring shift-subtract algorithm, one quotient bit per cycle, MSB first, for exactly 32 cycles, using a 5-bit iteration counter.
REQ-014 On the 32nd CALC edge the block SHALL load the final result into result and enter DONE; done=1 only while in DONE, and the next edge returns the FSM to IDLE.
REQ-015 Normal latency SHALL be: accept edge E0, done high in the cycle after edge E32 (33 cycles).
REQ-016 Signed fix-up: for DIV, negate the quotient when the operand signs differ; for REM, the remainder takes the sign of the dividend.
REQ-017 A divisor of zero SHALL give DIV/DIVU = 0xFFFFFFFF and REM/REMU = A, for any sign of A.
REQ-018 Signed overflow (DIV or REM with A=0x80000000, B=0xFFFFFFFF) SHALL give DIV = 0x80000000 and REM = 0.
REQ-019 result SHALL hold its value from DONE until the next result load; start, A, B and ALUCtrl changes while busy SHALL have no effect.
REQ-020 A start presented in the DONE cycle SHALL be ignored; it is accepted only from IDLE on the following cycle.

Reset
REQ-021 While rst=1 the block SHALL immediately force the state to IDLE and set busy=0, done=0, result=0x00000000, and clear the counter and all internal registers, including mid-operation.
REQ-022 After rst deasserts, the first start SHALL be accepted normally with no residual state.

Configuration
REQ-023 Macro DIV_EARLY_OUT_EN: when defined, a divide-by-zero or signed-overflow start SHALL skip CALC, load result per REQ-017/018 on the accept edge and go straight to DONE (done in the cycle after E0).
REQ-024 When DIV_EARLY_OUT_EN is undefined, those cases SHALL take the full 33-cycle path and still produce the REQ-017/018 values; all other ops behave identically with or without the macro.

Verification
REQ-025 DIV A=0xFFFFFFF9 (-7), B=2 -> result 0xFFFFFFFD, done exactly 33 cycles after accept; REM with the same operands -> 0xFFFFFFFF.
REQ-026 DIVU A=100, B=7 -> 14; REMU -> 2; DIVU A=0xFFFFFFFF, B=1 -> 0xFFFFFFFF.
REQ-027 DIV A=0xFFFFFFFB, B=0 -> 0xFFFFFFFF; REMU A=5, B=0 -> 5; latency 1 cycle with DIV_EARLY_OUT_EN, 33 cycles without.
REQ-028 DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-029 Start a DIVU, pulse start with new operands at cycle 5 -> ignored, original result delivered; assert rst at cycle 10 of the next op -> busy=0, done=0, result=0 immediately; a following DIVU 9/3 -> 3.
REQ-030 start=1 with ALUCtrl=`ALU_MUL -> busy stays 0, no done pulse, result unchanged.
